// File: rtl/cam_vga_capture.sv
// OV7670-style RGB444 capture into an on-chip frame buffer,
// shown as a 160x120 window at the top-left of a 640x480 VGA screen.
module cam_vga_capture #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int AW     = 15,
    parameter int DW     = 12,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_PCLK,
    input  logic          CAM_HREF,
    input  logic          CAM_VSYNC,
    input  logic [7:0]    CAM_px_data,
    output logic          CAM_xclk,
    output logic          CAM_pwdn,
    output logic          CAM_reset,
    output logic          clk25M,
    output logic          VGA_Hsync_n,
    output logic          VGA_Vsync_n,
    output logic [3:0]    VGA_R,
    output logic [3:0]    VGA_G,
    output logic [3:0]    VGA_B,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic [AW-1:0] DP_RAM_addr_out,
    output logic [DW-1:0] data_mem
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int IW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HS_B  = H_ACT + H_FP;
    localparam int HS_E  = HS_B + H_SYNC - 1;
    localparam int VS_B  = V_ACT + V_FP;
    localparam int VS_E  = VS_B + V_SYNC - 1;
    localparam logic [AW-1:0] LAST_A = AW'(NPIX - 1);
    localparam logic [AW-1:0] W_A    = AW'(IMG_W);

    typedef enum logic [1:0] {IDLE, BYTE1, BYTE2} cap_st_t;

    logic [1:0]    div;
    logic          pe;
    logic          pclk_s1, pclk_s2, pclk_d;
    logic          href_s1, href_s2;
    logic          vs_s1, vs_s2;
    logic [7:0]    px_s1, px_s2;
    logic          pclk_rise;
    cap_st_t       state, state_n;
    logic          ld_r, wr_go, clr;
    logic [3:0]    r_lat;
    logic          full;
    logic [DW-1:0] mem [NPIX];
    logic [9:0]    hcnt, vcnt;
    logic          in_win;

    assign pe        = (div == 2'd3);
    assign clk25M    = div[1];
    assign CAM_xclk  = div[1];
    assign CAM_pwdn  = 1'b0;
    assign CAM_reset = 1'b1;
    assign pclk_rise = pclk_s2 & ~pclk_d;

    // free-running divider giving the 25 MHz clock and pixel enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div <= '0;
        else      div <= div + 2'd1;
    end

    // two-flop synchronisers plus delayed PCLK for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pclk_s1 <= 1'b0; pclk_s2 <= 1'b0; pclk_d <= 1'b0;
            href_s1 <= 1'b0; href_s2 <= 1'b0;
            vs_s1   <= 1'b0; vs_s2   <= 1'b0;
            px_s1   <= '0;   px_s2   <= '0;
        end else begin
            pclk_s1 <= CAM_PCLK;    pclk_s2 <= pclk_s1; pclk_d <= pclk_s2;
            href_s1 <= CAM_HREF;    href_s2 <= href_s1;
            vs_s1   <= CAM_VSYNC;   vs_s2   <= vs_s1;
            px_s1   <= CAM_px_data; px_s2   <= px_s1;
        end
    end

    // capture state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // capture next state: pair bytes into one RGB444 word
    always_comb begin
        state_n = state;
        ld_r    = 1'b0;
        wr_go   = 1'b0;
        clr     = 1'b0;
        if (pclk_rise) begin
            if (vs_s2) begin
                state_n = IDLE;
                clr     = 1'b1;
            end else begin
                unique case (state)
                    IDLE: if (href_s2) begin
                        ld_r    = 1'b1;
                        state_n = BYTE2;
                    end
                    BYTE1: if (href_s2) begin
                        ld_r    = 1'b1;
                        state_n = BYTE2;
                    end else begin
                        state_n = BYTE1;
                    end
                    BYTE2: begin
                        wr_go   = href_s2;
                        state_n = BYTE1;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    // write strobe, data and saturating address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat          <= '0;
            DP_RAM_data_in <= '0;
            DP_RAM_regW    <= 1'b0;
            DP_RAM_addr_in <= '0;
            full           <= 1'b0;
        end else begin
            DP_RAM_regW <= 1'b0;
            if (ld_r) r_lat <= px_s2[3:0];
            if (wr_go && !full) begin
                DP_RAM_data_in <= {r_lat, px_s2};
                DP_RAM_regW    <= 1'b1;
            end
            if (clr) begin
                DP_RAM_addr_in <= '0;
                full           <= 1'b0;
            end else if (DP_RAM_regW) begin
                if (DP_RAM_addr_in == LAST_A) full <= 1'b1;
                else DP_RAM_addr_in <= DP_RAM_addr_in + 1'b1;
            end
        end
    end

    // frame buffer write port
    always_ff @(posedge clk) begin
        if (DP_RAM_regW) mem[DP_RAM_addr_in[IW-1:0]] <= DP_RAM_data_in;
    end

    // frame buffer read port, old data on same-address collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) data_mem <= '0;
        else      data_mem <= mem[DP_RAM_addr_out[IW-1:0]];
    end

    // VGA raster counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pe) begin
            if (hcnt == 10'(H_TOT - 1)) begin
                hcnt <= '0;
                if (vcnt == 10'(V_TOT - 1)) vcnt <= '0;
                else                        vcnt <= vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    assign in_win = (hcnt < 10'(IMG_W)) && (vcnt < 10'(IMG_H));

    always_comb begin
        DP_RAM_addr_out = '0;
        if (in_win) DP_RAM_addr_out = AW'(vcnt) * W_A + AW'(hcnt);
    end

    // colour and sync registered together on the pixel enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_Hsync_n <= 1'b1;
            VGA_Vsync_n <= 1'b1;
        end else if (pe) begin
            VGA_R <= in_win ? data_mem[11:8] : 4'd0;
            VGA_G <= in_win ? data_mem[7:4]  : 4'd0;
            VGA_B <= in_win ? data_mem[3:0]  : 4'd0;
            VGA_Hsync_n <= !((hcnt >= 10'(HS_B)) && (hcnt <= 10'(HS_E)));
            VGA_Vsync_n <= !((vcnt >= 10'(VS_B)) && (vcnt <= 10'(VS_E)));
        end
    end

endmodule

// File: tb/tb_cam_vga_capture.sv
// Directed bench: a full-size instance for capture checks and a
// short-frame instance for saturation and VGA raster checks.
module tb_cam_vga_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        CAM_PCLK = 1'b0;
    logic        CAM_HREF = 1'b0;
    logic        CAM_VSYNC = 1'b0;
    logic [7:0]  CAM_px_data = 8'h00;

    logic        xclk, pwdn, creset, c25, hs_n, vs_n;
    logic [3:0]  vr, vg, vb;
    logic [14:0] wa, ra;
    logic [11:0] wd, rd;
    logic        we;

    logic        xclk_s, pwdn_s, creset_s, c25_s, hs_n_s, vs_n_s;
    logic [3:0]  vr_s, vg_s, vb_s;
    logic [14:0] wa_s, ra_s;
    logic [11:0] wd_s, rd_s;
    logic        we_s;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          wc = 0, a_err = 0, d_err = 0, dbl = 0;
    int          wc_s = 0, dbl_s = 0;
    logic [14:0] last_a = '0, last_a_s = '0, m_a = '0;
    logic [11:0] last_d = '0;
    logic        pw = 1'b0, pw_s = 1'b0;
    logic        pat_on = 1'b0;

    cam_vga_capture dut (
        .clk(clk), .rst(rst),
        .CAM_PCLK(CAM_PCLK), .CAM_HREF(CAM_HREF),
        .CAM_VSYNC(CAM_VSYNC), .CAM_px_data(CAM_px_data),
        .CAM_xclk(xclk), .CAM_pwdn(pwdn), .CAM_reset(creset),
        .clk25M(c25), .VGA_Hsync_n(hs_n), .VGA_Vsync_n(vs_n),
        .VGA_R(vr), .VGA_G(vg), .VGA_B(vb),
        .DP_RAM_addr_in(wa), .DP_RAM_data_in(wd),
        .DP_RAM_regW(we), .DP_RAM_addr_out(ra), .data_mem(rd)
    );

    cam_vga_capture #(
        .IMG_H(3), .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clk(clk), .rst(rst),
        .CAM_PCLK(CAM_PCLK), .CAM_HREF(CAM_HREF),
        .CAM_VSYNC(CAM_VSYNC), .CAM_px_data(CAM_px_data),
        .CAM_xclk(xclk_s), .CAM_pwdn(pwdn_s), .CAM_reset(creset_s),
        .clk25M(c25_s), .VGA_Hsync_n(hs_n_s), .VGA_Vsync_n(vs_n_s),
        .VGA_R(vr_s), .VGA_G(vg_s), .VGA_B(vb_s),
        .DP_RAM_addr_in(wa_s), .DP_RAM_data_in(wd_s),
        .DP_RAM_regW(we_s), .DP_RAM_addr_out(ra_s), .data_mem(rd_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // write monitor: expected address restarts on camera VSYNC
    always @(negedge clk) begin
        if (CAM_VSYNC) m_a = '0;
        if (we) begin
            wc++;
            last_a = wa;
            last_d = wd;
            if (wa != m_a) a_err++;
            if (pat_on && wd != (m_a[0] ? 12'hF0F : 12'h0F0)) d_err++;
            m_a = m_a + 15'd1;
        end
        if (we && pw) dbl++;
        pw = we;
        if (we_s) begin
            wc_s++;
            last_a_s = wa_s;
        end
        if (we_s && pw_s) dbl_s++;
        pw_s = we_s;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cam_byte(input logic [7:0] b, input logic h,
                            input logic v);
        @(posedge clk); #1;
        CAM_PCLK = 1'b0; CAM_px_data = b; CAM_HREF = h; CAM_VSYNC = v;
        @(posedge clk); @(posedge clk); #1;
        CAM_PCLK = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle2();
        cam_byte(8'h00, 1'b0, 1'b0);
        cam_byte(8'h00, 1'b0, 1'b0);
    endtask

    task automatic vsync_pulse();
        repeat (3) cam_byte(8'h00, 1'b0, 1'b1);
        idle2();
    endtask

    task automatic std_line();
        for (int i = 0; i < 80; i++) begin
            cam_byte(8'hF0, 1'b1, 1'b0);
            cam_byte(8'hF0, 1'b1, 1'b0);
            cam_byte(8'h0F, 1'b1, 1'b0);
            cam_byte(8'h0F, 1'b1, 1'b0);
        end
        idle2();
    endtask

    task automatic wait_cyc(input int t);
        int n = 0;
        while (cyc != t && n < 70000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cyc", cyc, t);
    endtask

    task automatic pix(input string tag, input int fb, input int p,
                       input logic [14:0] ea, input logic [11:0] ec);
        wait_cyc(fb + 4 * p + 2);
        chk({tag, "_raddr"}, ra_s, ea);
        wait_cyc(fb + 4 * p + 6);
        chk({tag, "_rgb"}, {vr_s, vg_s, vb_s}, ec);
    endtask

    initial begin
        int w0, w1, hl, hl0, vl, fb;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_c25", c25, 0);
        chk("rst_rgb", {vr, vg, vb}, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", wa, 0);
        chk("rst_wdata", wd, 0);
        chk("rst_raddr", ra, 0);
        chk("rst_rdata", rd, 0);
        chk("rst_hs", hs_n, 1);
        chk("rst_vs", vs_n, 1);
        chk("pwdn", pwdn, 0);
        chk("cam_reset", creset, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("c25_div", c25, ((cyc % 4) >= 2) ? 1 : 0);
            chk("xclk", xclk, ((cyc % 4) >= 2) ? 1 : 0);
        end

        vsync_pulse();
        pat_on = 1'b1;
        std_line();
        chk("l0_count", wc, 160);
        chk("l0_last_a", last_a, 159);
        chk("l0_last_d", last_d, 12'hF0F);
        std_line();
        std_line();
        chk("s_count3", wc_s, 480);
        chk("s_last_a", last_a_s, 479);
        w0 = wc_s;
        std_line();
        pat_on = 1'b0;
        chk("s_sat_none", wc_s - w0, 0);
        chk("s_sat_addr", wa_s, 479);
        chk("l4_count", wc, 640);
        chk("l4_last_a", last_a, 639);
        chk("addr_seq", a_err, 0);
        chk("data_pat", d_err, 0);
        chk("one_clk", dbl, 0);
        chk("s_one_clk", dbl_s, 0);

        w1 = wc;
        cam_byte(8'h35, 1'b1, 1'b0);
        cam_byte(8'h6A, 1'b1, 1'b0);
        cam_byte(8'h9C, 1'b1, 1'b0);
        idle2();
        chk("part_count", wc - w1, 1);
        chk("part_a", last_a, 640);
        chk("part_d", last_d, 12'h56A);
        cam_byte(8'h12, 1'b1, 1'b0);
        cam_byte(8'h34, 1'b1, 1'b0);
        idle2();
        chk("next_a", last_a, 641);
        chk("next_d", last_d, 12'h234);

        vsync_pulse();
        cam_byte(8'hAB, 1'b1, 1'b0);
        cam_byte(8'hCD, 1'b1, 1'b0);
        idle2();
        chk("vs_a", last_a, 0);
        chk("vs_d", last_d, 12'hBCD);
        chk("vs_seq", a_err, 0);

        hl = 0; hl0 = 0;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            if (!hs_n_s) hl++;
            if (!hs_n) hl0++;
        end
        chk("hs_low", hl, 384);
        chk("hs_low_full", hl0, 384);
        vl = 0;
        for (int i = 0; i < 25600; i++) begin
            @(negedge clk);
            if (!vs_n_s) vl++;
        end
        chk("vs_low", vl, 6400);

        fb = ((cyc / 25600) + 1) * 25600;
        pix("px4_2", fb, 1604, 15'd324, 12'h0F0);
        pix("px5_2", fb, 1605, 15'd325, 12'hF0F);
        pix("px200_2", fb, 1800, 15'd0, 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
